// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: the W stage always wins, multi-cycle results queue in a small FIFO.
// A scoreboard tracks registers with outstanding multi-cycle writes so decode can stall on them.
module grf_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_we,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic [31:0] a_pc,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic [31:0] b_pc,
    input  logic        b_issue,
    input  logic [4:0]  b_issue_addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        regwrite,
    output logic [4:0]  writereg,
    output logic [31:0] writedata,
    output logic [31:0] pc
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] pending;
    logic [31:0] pending_next;
    logic        empty;
    logic        full;
    logic        a_eff;
    logic        push;
    logic        pop;

    // Extra wrap bit separates full (same index, different lap) from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign b_ready = !full;
    assign a_eff   = a_we && (a_addr != 5'd0);
    // Zero-destination results are accepted from the unit but never stored.
    assign push    = b_valid && b_ready && (b_addr != 5'd0);
    assign pop     = !a_eff && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    assign rs_busy = pending[rs_addr];
    assign rt_busy = pending[rt_addr];

    // NOTE: storage has no reset; the pointers alone define which slots hold live data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{addr: b_addr, data: b_data, pc: b_pc};
        end
    end

    // NOTE: combinational blocks start from a default so no path leaves a latch behind.
    always_comb begin
        pending_next = pending;
        if (pop) begin
            pending_next[head.addr] = 1'b0;
        end
        if (b_issue && (b_issue_addr != 5'd0)) begin
            pending_next[b_issue_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pending   <= '0;
            regwrite  <= 1'b0;
            writereg  <= 5'd0;
            writedata <= 32'd0;
            pc        <= 32'd0;
        end else begin
            pending <= pending_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (a_eff) begin
                regwrite  <= 1'b1;
                writereg  <= a_addr;
                writedata <= a_data;
                pc        <= a_pc;
            end else if (pop) begin
                regwrite  <= 1'b1;
                writereg  <= head.addr;
                writedata <= head.data;
                pc        <= head.pc;
            end else begin
                regwrite  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter with DEPTH=2: A priority, B buffering, scoreboard and reset.
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic [31:0] a_pc;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [31:0] b_pc;
    logic        b_issue;
    logic [4:0]  b_issue_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_busy;
    logic        rt_busy;
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_pc(a_pc),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data), .b_pc(b_pc),
        .b_issue(b_issue), .b_issue_addr(b_issue_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .regwrite(regwrite), .writereg(writereg), .writedata(writedata), .pc(pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_we = 1'b0; a_addr = 5'd0; a_data = 32'd0; a_pc = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0; b_pc = 32'd0;
        b_issue = 1'b0; b_issue_addr = 5'd0;
    endtask

    task automatic expect_write(input string name, input logic [4:0] reg_exp,
                                input logic [31:0] data_exp, input logic [31:0] pc_exp);
        checks++;
        if (regwrite !== 1'b1 || writereg !== reg_exp || writedata !== data_exp || pc !== pc_exp) begin
            errors++;
            $display("FAIL %s: got we=%0b reg=%0d data=%h pc=%h, want we=1 reg=%0d data=%h pc=%h",
                     name, regwrite, writereg, writedata, pc, reg_exp, data_exp, pc_exp);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rs_addr = 5'd0; rt_addr = 5'd0;
        reset = 1'b0;
        #12;
        checks++;
        if (regwrite !== 1'b0 || writereg !== 5'd0 || writedata !== 32'd0 || pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%0b reg=%0d data=%h pc=%h, want all zero",
                     regwrite, writereg, writedata, pc);
        end
        checks++;
        if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got rs=%0b rt=%0b, want 0 0", rs_busy, rt_busy);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %0b want 1", b_ready);
        end
    endtask

    task automatic test_a_write();
        a_we = 1'b1; a_addr = 5'd5; a_data = 32'h1234; a_pc = 32'h3000;
        tick();
        expect_write("a_write", 5'd5, 32'h1234, 32'h3000);
        idle_inputs();
        tick();
        checks++;
        if (regwrite !== 1'b0 || writereg !== 5'd5 || writedata !== 32'h1234 || pc !== 32'h3000) begin
            errors++;
            $display("FAIL idle_hold: got we=%0b reg=%0d data=%h pc=%h, want we=0 reg=5 data=1234 pc=3000",
                     regwrite, writereg, writedata, pc);
        end
    endtask

    task automatic test_a_zero();
        a_we = 1'b1; a_addr = 5'd0; a_data = 32'hDEAD; a_pc = 32'h3004;
        tick();
        checks++;
        if (regwrite !== 1'b0 || writedata !== 32'h1234) begin
            errors++;
            $display("FAIL a_zero: got we=%0b data=%h, want we=0 data=1234", regwrite, writedata);
        end
        idle_inputs();
    endtask

    task automatic test_b_path();
        b_issue = 1'b1; b_issue_addr = 5'd8;
        tick();
        b_issue = 1'b0; b_issue_addr = 5'd0;
        rs_addr = 5'd8; rt_addr = 5'd8;
        #1;
        checks++;
        if (rs_busy !== 1'b1 || rt_busy !== 1'b1) begin
            errors++;
            $display("FAIL b_busy_set: got rs=%0b rt=%0b, want 1 1", rs_busy, rt_busy);
        end
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'hBEEF; b_pc = 32'h4000;
        tick();
        b_valid = 1'b0;
        checks++;
        if (regwrite !== 1'b0 || rs_busy !== 1'b1) begin
            errors++;
            $display("FAIL b_no_bypass: got we=%0b rs_busy=%0b, want 0 1", regwrite, rs_busy);
        end
        tick();
        expect_write("b_write", 5'd8, 32'hBEEF, 32'h4000);
        checks++;
        if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
            errors++;
            $display("FAIL b_busy_clear: got rs=%0b rt=%0b, want 0 0", rs_busy, rt_busy);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        a_we = 1'b1; a_addr = 5'd1; a_data = 32'h11; a_pc = 32'h100;
        b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hA0; b_pc = 32'h5000;
        tick();
        expect_write("btb_a1", 5'd1, 32'h11, 32'h100);
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL btb_ready_one: got %0b want 1", b_ready);
        end
        a_addr = 5'd2; a_data = 32'h22; a_pc = 32'h104;
        b_addr = 5'd11; b_data = 32'hB0; b_pc = 32'h5004;
        tick();
        expect_write("btb_a2", 5'd2, 32'h22, 32'h104);
        checks++;
        if (b_ready !== 1'b0) begin
            errors++;
            $display("FAIL btb_ready_full: got %0b want 0", b_ready);
        end
        // Offered while full: must be refused and never reach the GRF.
        a_addr = 5'd3; a_data = 32'h33; a_pc = 32'h108;
        b_addr = 5'd12; b_data = 32'hC0; b_pc = 32'h5008;
        tick();
        expect_write("btb_a3", 5'd3, 32'h33, 32'h108);
        checks++;
        if (b_ready !== 1'b0) begin
            errors++;
            $display("FAIL btb_hold_full: got %0b want 0", b_ready);
        end
        idle_inputs();
        tick();
        expect_write("btb_b1", 5'd10, 32'hA0, 32'h5000);
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL btb_ready_after_pop: got %0b want 1", b_ready);
        end
        tick();
        expect_write("btb_b2", 5'd11, 32'hB0, 32'h5004);
        tick();
        checks++;
        if (regwrite !== 1'b0) begin
            errors++;
            $display("FAIL btb_drained: got we=%0b reg=%0d, want we=0", regwrite, writereg);
        end
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFF; b_pc = 32'h6000;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (regwrite !== 1'b0 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL b_zero_discard: got we=%0b ready=%0b, want 0 1", regwrite, b_ready);
        end
    endtask

    task automatic test_set_clear();
        b_issue = 1'b1; b_issue_addr = 5'd9;
        rs_addr = 5'd9; rt_addr = 5'd0;
        tick();
        b_issue = 1'b0;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99; b_pc = 32'h7000;
        tick();
        b_valid = 1'b0;
        b_issue = 1'b1; b_issue_addr = 5'd9;
        tick();
        b_issue = 1'b0; b_issue_addr = 5'd0;
        expect_write("sc_pop9", 5'd9, 32'h99, 32'h7000);
        checks++;
        if (rs_busy !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got rs_busy=%0b want 1", rs_busy);
        end
        tick();
        checks++;
        if (rs_busy !== 1'b1 || rt_busy !== 1'b0) begin
            errors++;
            $display("FAIL set_persists: got rs=%0b rt=%0b, want 1 0", rs_busy, rt_busy);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        b_issue = 1'b1; b_issue_addr = 5'd7;
        rs_addr = 5'd7; rt_addr = 5'd9;
        tick();
        b_issue = 1'b0;
        a_we = 1'b1; a_addr = 5'd3; a_data = 32'h3333; a_pc = 32'h8000;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77; b_pc = 32'h8004;
        tick();
        idle_inputs();
        expect_write("rm_a_before", 5'd3, 32'h3333, 32'h8000);
        reset = 1'b0;
        #1;
        checks++;
        if (regwrite !== 1'b0 || writereg !== 5'd0 || writedata !== 32'd0 || pc !== 32'd0) begin
            errors++;
            $display("FAIL rm_async: got we=%0b reg=%0d data=%h pc=%h, want all zero",
                     regwrite, writereg, writedata, pc);
        end
        checks++;
        if (b_ready !== 1'b1 || rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_state: got ready=%0b rs=%0b rt=%0b, want 1 0 0", b_ready, rs_busy, rt_busy);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (regwrite !== 1'b0 || b_ready !== 1'b1) begin
                errors++;
                $display("FAIL rm_after_release[%0d]: got we=%0b reg=%0d ready=%0b, want we=0 ready=1",
                         i, regwrite, writereg, b_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_a_write();
        test_a_zero();
        test_b_path();
        test_back_to_back();
        test_set_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
